// File: rtl/rv32i_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_dmem_arbiter
//  Description : Round-robin arbiter sharing the single-port data memory
//                between the core MEM stage and the loader/debug port.
//                Issues one access per cycle and returns a one-cycle
//                response pulse to the winner. It also keeps a saturating
//                count of cycles in which both sides contend.
//                Optional macro ARB_CORE_PRIO_EN selects fixed core priority
//                in place of round-robin.
//  Revision    : 1.0  initial release
// ============================================================================
module rv32i_dmem_arbiter #(
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             RN,

    input  logic             core_req_valid,
    output logic             core_req_ready,
    input  logic             core_req_we,
    input  logic [AW-1:0]    core_req_addr,
    input  logic [DW-1:0]    core_req_wdata,
    output logic             core_rsp_valid,
    output logic [DW-1:0]    core_rsp_rdata,

    input  logic             ldr_req_valid,
    output logic             ldr_req_ready,
    input  logic             ldr_req_we,
    input  logic [AW-1:0]    ldr_req_addr,
    input  logic [DW-1:0]    ldr_req_wdata,
    output logic             ldr_rsp_valid,
    output logic [DW-1:0]    ldr_rsp_rdata,

    output logic             mem_en,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata,
    input  logic [DW-1:0]    mem_rdata,

    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic             OWN_CORE = 1'b0;
    localparam logic             OWN_LDR  = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Arbitration history and response tags
    logic             last_grant_q, last_grant_d;
    logic             core_pend_q,  core_pend_d;
    logic             ldr_pend_q,   ldr_pend_d;
    logic             rd_pend_q,    rd_pend_d;
    logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

    logic             core_win;
    logic             ldr_win;

    // Grant decision: a winner only exists among valid requesters, and no
    // grant is issued while reset is asserted.
    always_comb begin
        core_win = 1'b0;
        ldr_win  = 1'b0;
        if (!RN) begin
`ifdef ARB_CORE_PRIO_EN
            core_win = core_req_valid;
`else
            core_win = core_req_valid && (!ldr_req_valid || (last_grant_q == OWN_LDR));
`endif
            ldr_win  = ldr_req_valid && !core_win;
        end
    end

    // Handshake and memory issue mux driven from the winner in the accept cycle
    always_comb begin
        core_req_ready = core_win;
        ldr_req_ready  = ldr_win;
        mem_en         = core_win || ldr_win;
        mem_we         = 1'b0;
        mem_addr       = core_req_addr;
        mem_wdata      = core_req_wdata;
        if (core_win) begin
            mem_we = core_req_we;
        end else if (ldr_win) begin
            mem_we    = ldr_req_we;
            mem_addr  = ldr_req_addr;
            mem_wdata = ldr_req_wdata;
        end
    end

    // Next-state: grant history, response tags and contention counter
    always_comb begin
        last_grant_d   = last_grant_q;
        core_pend_d    = core_win;
        ldr_pend_d     = ldr_win;
        rd_pend_d      = !mem_we;
        conflict_cnt_d = conflict_cnt_q;
`ifndef ARB_CORE_PRIO_EN
        if (core_win) begin
            last_grant_d = OWN_CORE;
        end else if (ldr_win) begin
            last_grant_d = OWN_LDR;
        end
`endif
        if (core_req_valid && ldr_req_valid && (conflict_cnt_q != CNT_MAX)) begin
            conflict_cnt_d = conflict_cnt_q + CNT_ONE;
        end
    end

    // State registers; reset makes the core win the first tie
    always_ff @(posedge clk) begin
        if (RN) begin
            last_grant_q   <= OWN_LDR;
            core_pend_q    <= 1'b0;
            ldr_pend_q     <= 1'b0;
            rd_pend_q      <= 1'b0;
            conflict_cnt_q <= '0;
        end else begin
            last_grant_q   <= last_grant_d;
            core_pend_q    <= core_pend_d;
            ldr_pend_q     <= ldr_pend_d;
            rd_pend_q      <= rd_pend_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    // Response pulses; a response in flight when reset arrives is suppressed.
    // Write acknowledgements carry zero data.
    always_comb begin
        core_rsp_valid = core_pend_q && !RN;
        ldr_rsp_valid  = ldr_pend_q  && !RN;
        core_rsp_rdata = (core_rsp_valid && rd_pend_q) ? mem_rdata : '0;
        ldr_rsp_rdata  = (ldr_rsp_valid  && rd_pend_q) ? mem_rdata : '0;
        conflict_cnt   = conflict_cnt_q;
    end

endmodule
`default_nettype wire
